writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 107 ++++++++++
 tb/tb_writeback_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Two-entry in-order write-back queue between MEM and the register file.
// Loads hold a slot until their data returns; the head retires once its data is present.
module writeback_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wb_en,
  input  logic        in_mem_read,
  input  logic [3:0]  in_dest,
  input  logic [31:0] in_alu_result,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  output logic        WB_en,
  output logic [3:0]  WB_destination,
  output logic [31:0] WB_data,
  output logic        hazard,
  output logic        load_pending
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 2;

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ok;
  logic [AW-1:0]    dst [DEPTH];
  logic [DW-1:0]    dat [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CW-1:0]    count;

  logic             push;
  logic             pop;
  logic             fill;
  logic             fill_idx;

  assign in_ready = rst & (count < CW'(DEPTH));
  assign push     = in_valid & in_ready & in_wb_en;

  // Head drives the register-file port; fields are forced to zero when idle.
  assign WB_en          = rst & vld[rd_ptr] & ok[rd_ptr];
  assign WB_destination = WB_en ? dst[rd_ptr] : AW'(0);
  assign WB_data        = WB_en ? dat[rd_ptr] : DW'(0);
  assign pop            = WB_en;

  // Oldest pending load takes the returned data; the head is older than its neighbour.
  always_comb begin
    fill     = 1'b0;
    fill_idx = rd_ptr;
    if (vld[rd_ptr] && !ok[rd_ptr]) begin
      fill     = mem_ready;
      fill_idx = rd_ptr;
    end else if (vld[~rd_ptr] && !ok[~rd_ptr]) begin
      fill     = mem_ready;
      fill_idx = ~rd_ptr;
    end
  end

  always_comb begin
    hazard       = 1'b0;
    load_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (dst[i] == src1 || (two_src && dst[i] == src2))) hazard = 1'b1;
      if (vld[i] && !ok[i]) load_pending = 1'b1;
    end
    hazard       = hazard & rst;
    load_pending = load_pending & rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld    <= '0;
      ok     <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dst[i] <= '0;
        dat[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ~rd_ptr;
      end
      if (fill) begin
        dat[fill_idx] <= mem_rdata;
        ok[fill_idx]  <= 1'b1;
      end
      // Push targets a free slot, so it never collides with pop or fill.
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        ok[wr_ptr]  <= ~in_mem_read;
        dst[wr_ptr] <= in_dest;
        dat[wr_ptr] <= in_mem_read ? DW'(0) : in_alu_result;
        wr_ptr      <= ~wr_ptr;
      end
      count <= CW'(count + CW'(push) - CW'(pop));
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wb_en;
  logic        in_mem_read;
  logic [3:0]  in_dest;
  logic [31:0] in_alu_result;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        WB_en;
  logic [3:0]  WB_destination;
  logic [31:0] WB_data;
  logic        hazard;
  logic        load_pending;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
    bit          ok;
  } ent_t;
  ent_t q[$];

  writeback_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
    .in_mem_read(in_mem_read), .in_dest(in_dest), .in_alu_result(in_alu_result),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .src1(src1), .src2(src2), .two_src(two_src),
    .WB_en(WB_en), .WB_destination(WB_destination), .WB_data(WB_data),
    .hazard(hazard), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance one edge.
  task automatic step();
    logic        e_wb;
    logic        e_hz;
    logic        e_lp;
    bit          do_pop;
    int unsigned pre;
    #1;
    e_wb = rst && q.size() > 0 && q[0].ok;
    e_hz = 1'b0;
    e_lp = 1'b0;
    foreach (q[i]) begin
      if (q[i].dest == src1 || (two_src && q[i].dest == src2)) e_hz = 1'b1;
      if (!q[i].ok) e_lp = 1'b1;
    end
    check("in_ready", 32'(in_ready), 32'(rst && q.size() < 2));
    check("wb_en", 32'(WB_en), 32'(e_wb));
    check("wb_dest", 32'(WB_destination), e_wb ? 32'(q[0].dest) : 32'd0);
    check("wb_data", WB_data, e_wb ? q[0].data : 32'd0);
    check("hazard", 32'(hazard), 32'(rst & e_hz));
    check("load_pending", 32'(load_pending), 32'(rst & e_lp));
    @(posedge clk);
    if (!rst) begin
      q.delete();
    end else begin
      pre    = q.size();
      do_pop = e_wb;
      if (mem_ready) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].ok) begin
            q[i].ok   = 1'b1;
            q[i].data = mem_rdata;
            break;
          end
        end
      end
      if (do_pop) void'(q.pop_front());
      if (in_valid && in_wb_en && pre < 2)
        q.push_back('{dest: in_dest, data: in_mem_read ? 32'd0 : in_alu_result, ok: !in_mem_read});
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_wb_en = 0; in_mem_read = 0; in_dest = 0; in_alu_result = 0;
    mem_ready = 0; mem_rdata = 0; src1 = 0; src2 = 0; two_src = 0;
  endtask

  task automatic offer(input logic ld, input logic [3:0] d, input logic [31:0] v);
    in_valid = 1; in_wb_en = 1; in_mem_read = ld; in_dest = d; in_alu_result = v;
  endtask

  initial begin
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    step();
    rst = 1;

    // Single ALU result
    offer(0, 4'd3, 32'h1234); step();
    idle(); #1;
    check("alu_wb_en", 32'(WB_en), 32'd1);
    check("alu_dest", 32'(WB_destination), 32'd3);
    check("alu_data", WB_data, 32'h1234);
    step(); #1;
    check("alu_once", 32'(WB_en), 32'd0);
    step();

    // Load then ALU, load data returns late and both retire in order
    offer(1, 4'd5, 32'hDEAD); step();
    offer(0, 4'd6, 32'd7); step();
    idle(); #1;
    check("full_ready", 32'(in_ready), 32'd0);
    check("blocked_head", 32'(WB_en), 32'd0);
    step();
    mem_ready = 1; mem_rdata = 32'hCAFE; step();
    idle(); #1;
    check("load_dest", 32'(WB_destination), 32'd5);
    check("load_data", WB_data, 32'hCAFE);
    step(); #1;
    check("young_dest", 32'(WB_destination), 32'd6);
    check("young_data", WB_data, 32'd7);
    step(); step();

    // Hazard including the entry being written back this cycle
    offer(0, 4'd4, 32'd1); step();
    idle(); src1 = 4; #1;
    check("hz_src1", 32'(hazard), 32'd1);
    src1 = 0; src2 = 4; two_src = 1; #1;
    check("hz_src2", 32'(hazard), 32'd1);
    two_src = 0; #1;
    check("hz_one_src", 32'(hazard), 32'd0);
    step();
    src1 = 4; #1;
    check("hz_retired", 32'(hazard), 32'd0);
    idle(); step();

    // Spurious return into an empty queue
    mem_ready = 1; mem_rdata = 32'h55; step();
    idle(); #1;
    check("spur_wb", 32'(WB_en), 32'd0);
    check("spur_lp", 32'(load_pending), 32'd0);
    step();

    // Reset while a load is outstanding
    offer(1, 4'd2, 32'd0); step();
    idle(); #1;
    check("lp_set", 32'(load_pending), 32'd1);
    rst = 0; step();
    rst = 1; mem_ready = 1; mem_rdata = 32'hBEEF; #1;
    check("rel_ready", 32'(in_ready), 32'd1);
    step();
    idle(); #1;
    check("drop_wb", 32'(WB_en), 32'd0);
    step();

    // Push and pop on the same edge
    offer(0, 4'd1, 32'd11); step();
    offer(0, 4'd9, 32'd22); #1;
    check("pp_head", 32'(WB_destination), 32'd1);
    step();
    idle(); #1;
    check("pp_next_dest", 32'(WB_destination), 32'd9);
    check("pp_next_data", WB_data, 32'd22);
    step(); step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 60) != 0);
      in_valid      = ($urandom_range(0, 9) < 6);
      in_wb_en      = ($urandom_range(0, 9) < 8);
      in_mem_read   = ($urandom_range(0, 9) < 4);
      in_dest       = 4'($urandom);
      in_alu_result = $urandom;
      mem_ready     = ($urandom_range(0, 9) < 3);
      mem_rdata     = $urandom;
      src1          = 4'($urandom);
      src2          = 4'($urandom);
      two_src       = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
